// File: rtl/bsg_dmc_pkg.sv
// Shared types and defaults for the DMC request scheduler.
// Used by the scheduler and bsg_chip_guts.
package bsg_dmc_pkg;

  localparam int dmc_addr_width_gp       = 28;
  // tREFI / core period
  localparam int dmc_refresh_interval_gp = 780;
  localparam int dmc_max_postpone_gp     = 8;

  typedef struct packed {
    logic                         we;
    logic [dmc_addr_width_gp-1:0] addr;
  } bsg_dmc_cmd_s;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_REF
  } sched_state_e;

endpackage

// File: rtl/bsg_dmc_rr_pick.sv
// Rotate-priority encoder.
// Searches from p_i upward with wrap and picks the first valid.
module bsg_dmc_rr_pick
  import bsg_dmc_pkg::*;
#(
  parameter int num_req_p = 4
) (
  input  logic [num_req_p-1:0]         req_v_i,
  input  logic [$clog2(num_req_p)-1:0] p_i,
  output logic [num_req_p-1:0]         grant_o,
  output logic [$clog2(num_req_p)-1:0] w_o
);

  localparam int lg_lp = $clog2(num_req_p);

  logic w_found;
  int   w_idx;

  always_comb begin
    grant_o = '0;
    w_o     = '0;
    w_found = 1'b0;
    w_idx   = 0;
    for (int k = 0; k < num_req_p; k++) begin
      w_idx = int'(p_i) + k;
      if (w_idx >= num_req_p)
        w_idx = w_idx - num_req_p;
      if (!w_found && req_v_i[w_idx]) begin
        w_found        = 1'b1;
        grant_o[w_idx] = 1'b1;
        w_o            = lg_lp'(w_idx);
      end
    end
  end

endmodule

// File: rtl/bsg_dmc_req_sched.sv
// Round-robin DRAM command scheduler with
// postponable periodic refresh.
module bsg_dmc_req_sched
  import bsg_dmc_pkg::*;
#(
  parameter int num_req_p          = 4,
  parameter int addr_width_p       = dmc_addr_width_gp,
  parameter int refresh_interval_p = dmc_refresh_interval_gp,
  parameter int max_postpone_p     = dmc_max_postpone_gp
) (
  input  logic                               clk_i,
  input  logic                               reset_n_i,
  input  logic [num_req_p-1:0]               req_v_i,
  input  logic [num_req_p-1:0]               req_we_i,
  input  logic [num_req_p-1:0][addr_width_p-1:0] req_addr_i,
  output logic [num_req_p-1:0]               req_ready_o,
  output logic                               cmd_v_o,
  output logic                               cmd_we_o,
  output logic [addr_width_p-1:0]            cmd_addr_o,
  output logic [$clog2(num_req_p)-1:0]       cmd_id_o,
  input  logic                               cmd_ready_i,
  output logic                               ref_v_o,
  input  logic                               ref_ready_i,
  output logic [$clog2(max_postpone_p+1)-1:0] ref_pending_o
);

  localparam int lg_req_lp  = $clog2(num_req_p);
  localparam int lg_pend_lp = $clog2(max_postpone_p+1);
  localparam int lg_tmr_lp  = $clog2(refresh_interval_p);
  localparam logic [lg_tmr_lp-1:0] c_reload =
    lg_tmr_lp'(refresh_interval_p-1);
  localparam logic [lg_pend_lp-1:0] c_max =
    lg_pend_lp'(max_postpone_p);

  sched_state_e              r_state;
  logic                      r_cmd_v;
  logic                      r_ref_v;
  logic                      r_we;
  logic [addr_width_p-1:0]   r_addr;
  logic [lg_req_lp-1:0]      r_id;
  logic [lg_req_lp-1:0]      r_p;
  logic [lg_pend_lp-1:0]     r_pending;
  logic [lg_tmr_lp-1:0]      r_timer;

  logic [num_req_p-1:0]      w_grant;
  logic [lg_req_lp-1:0]      w_win;
  logic [lg_req_lp-1:0]      w_p_nxt;
  logic                      w_load;
  logic                      w_force;
  logic                      w_any;
  logic                      w_tick;
  logic                      w_ref_hs;

  bsg_dmc_rr_pick #(
    .num_req_p(num_req_p)
  ) u_pick (
    .req_v_i(req_v_i),
    .p_i    (r_p),
    .grant_o(w_grant),
    .w_o    (w_win)
  );

  assign w_load   = (r_state == ST_IDLE)
                  | ((r_state == ST_CMD) & cmd_ready_i);
  assign w_force  = (r_pending == c_max);
  assign w_any    = |req_v_i;
  assign w_tick   = (r_timer == '0);
  assign w_ref_hs = (r_state == ST_REF) & ref_ready_i;
  assign w_p_nxt  = (w_win == lg_req_lp'(num_req_p-1))
                  ? '0 : w_win + lg_req_lp'(1);

  assign req_ready_o = (w_load & ~w_force) ? w_grant : '0;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state   <= ST_IDLE;
      r_cmd_v   <= 1'b0;
      r_ref_v   <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_id      <= '0;
      r_p       <= '0;
      r_pending <= '0;
      r_timer   <= c_reload;
    end else begin
      r_timer <= w_tick ? c_reload : r_timer - lg_tmr_lp'(1);
      // expiry and handshake together cancel out
      if (w_tick & ~w_ref_hs & ~w_force)
        r_pending <= r_pending + lg_pend_lp'(1);
      else if (w_ref_hs & ~w_tick)
        r_pending <= r_pending - lg_pend_lp'(1);
      if (w_load) begin
        if (w_force) begin
          r_state <= ST_REF;
          r_cmd_v <= 1'b0;
          r_ref_v <= 1'b1;
        end else if (w_any) begin
          r_state <= ST_CMD;
          r_cmd_v <= 1'b1;
          r_ref_v <= 1'b0;
          r_we    <= req_we_i[w_win];
          r_addr  <= req_addr_i[w_win];
          r_id    <= w_win;
          r_p     <= w_p_nxt;
        end else if (r_pending != '0) begin
          r_state <= ST_REF;
          r_cmd_v <= 1'b0;
          r_ref_v <= 1'b1;
        end else begin
          r_state <= ST_IDLE;
          r_cmd_v <= 1'b0;
          r_ref_v <= 1'b0;
        end
      end else if (w_ref_hs) begin
        r_state <= ST_IDLE;
        r_ref_v <= 1'b0;
      end
    end
  end

  assign cmd_v_o       = r_cmd_v;
  assign cmd_we_o      = r_we;
  assign cmd_addr_o    = r_addr;
  assign cmd_id_o      = r_id;
  assign ref_v_o       = r_ref_v;
  assign ref_pending_o = r_pending;

endmodule

// File: tb/tb_bsg_dmc_req_sched.sv
// Directed bench for bsg_dmc_req_sched.
// Small refresh interval to reach refresh corners quickly.
module tb_bsg_dmc_req_sched;

  localparam int NR = 4;
  localparam int AW = 28;

  logic                   clk;
  logic                   reset_n;
  logic [NR-1:0]          req_v;
  logic [NR-1:0]          req_we;
  logic [NR-1:0][AW-1:0]  req_addr;
  logic [NR-1:0]          req_ready;
  logic                   cmd_v;
  logic                   cmd_we;
  logic [AW-1:0]          cmd_addr;
  logic [1:0]             cmd_id;
  logic                   cmd_ready;
  logic                   ref_v;
  logic                   ref_ready;
  logic [1:0]             ref_pending;

  int n_chk;
  int n_err;
  int cyc;
  int max_pend;

  bsg_dmc_req_sched #(
    .num_req_p(NR),
    .addr_width_p(AW),
    .refresh_interval_p(16),
    .max_postpone_p(2)
  ) dut (
    .clk_i        (clk),
    .reset_n_i    (reset_n),
    .req_v_i      (req_v),
    .req_we_i     (req_we),
    .req_addr_i   (req_addr),
    .req_ready_o  (req_ready),
    .cmd_v_o      (cmd_v),
    .cmd_we_o     (cmd_we),
    .cmd_addr_o   (cmd_addr),
    .cmd_id_o     (cmd_id),
    .cmd_ready_i  (cmd_ready),
    .ref_v_o      (ref_v),
    .ref_ready_i  (ref_ready),
    .ref_pending_o(ref_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)",
               tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic rst_on();
    reset_n = 1'b0;
    #1;
  endtask

  task automatic rst_off();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    cyc = 0;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_addr(input logic [AW-1:0] base);
    for (int i = 0; i < NR; i++)
      req_addr[i] = base + AW'(i);
  endtask

  initial begin
    n_chk = 0; n_err = 0; cyc = 0; max_pend = 0;
    req_v = '0; req_we = 4'b1010; cmd_ready = 1'b1;
    ref_ready = 1'b0;
    set_addr(28'h100);

    // reset values
    rst_on();
    chk("rst_cmd_v", 32'(cmd_v), 0);
    chk("rst_ref_v", 32'(ref_v), 0);
    chk("rst_id", 32'(cmd_id), 0);
    chk("rst_addr", 32'(cmd_addr), 0);
    chk("rst_we", 32'(cmd_we), 0);
    chk("rst_pend", 32'(ref_pending), 0);
    chk("rst_rdy", 32'(req_ready), 0);
    rst_off();

    // round robin with all requesters valid
    req_v = 4'b1111;
    settle();
    chk("rr_rdy0", 32'(req_ready), 32'h1);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("rr_v", 32'(cmd_v), 1);
      chk("rr_id", 32'(cmd_id), 32'(k % 4));
      chk("rr_addr", 32'(cmd_addr), 32'h100 + 32'(k % 4));
      chk("rr_we", 32'(cmd_we), 32'(req_we[k % 4]));
      chk("rr_rdy", 32'(req_ready), 32'(1 << ((k + 1) % 4)));
    end
    req_v = '0;

    // backpressure holds command registers
    rst_on();
    rst_off();
    req_v = 4'b0010;
    cmd_ready = 1'b0;
    tick();
    chk("bp_v", 32'(cmd_v), 1);
    chk("bp_id", 32'(cmd_id), 1);
    req_v = 4'b1111;
    set_addr(28'hdead0);
    for (int k = 0; k < 5; k++) begin
      settle();
      chk("bp_rdy", 32'(req_ready), 0);
      tick();
      chk("bp_hold_v", 32'(cmd_v), 1);
      chk("bp_hold_id", 32'(cmd_id), 1);
      chk("bp_hold_addr", 32'(cmd_addr), 32'h101);
    end
    cmd_ready = 1'b1;
    settle();
    chk("bp_rel_rdy", 32'(req_ready), 32'h4);
    tick();
    chk("bp_rel_id", 32'(cmd_id), 2);
    chk("bp_rel_addr", 32'(cmd_addr), 32'hdead2);
    req_v = '0;
    set_addr(28'h100);

    // opportunistic refresh
    rst_on();
    rst_off();
    repeat (15) tick();
    chk("op_pend15", 32'(ref_pending), 0);
    tick();
    chk("op_pend16", 32'(ref_pending), 1);
    chk("op_ref16", 32'(ref_v), 0);
    tick();
    chk("op_ref17", 32'(ref_v), 1);
    chk("op_cmd17", 32'(cmd_v), 0);
    ref_ready = 1'b1;
    tick();
    chk("op_ref18", 32'(ref_v), 0);
    chk("op_pend18", 32'(ref_pending), 0);
    ref_ready = 1'b0;

    // forced refresh under continuous traffic
    rst_on();
    rst_off();
    req_v = 4'b0010;
    max_pend = 0;
    while (cyc < 40) begin
      tick();
      if (int'(ref_pending) > max_pend) max_pend = int'(ref_pending);
      if (cyc == 31) chk("fr_pend31", 32'(ref_pending), 1);
      if (cyc == 32) begin
        chk("fr_pend32", 32'(ref_pending), 2);
        chk("fr_cmd32", 32'(cmd_v), 1);
        chk("fr_rdy32", 32'(req_ready), 0);
      end
      if (cyc == 33) begin
        chk("fr_ref33", 32'(ref_v), 1);
        chk("fr_cmd33", 32'(cmd_v), 0);
      end
      if (cyc > 33) chk("fr_rdy_ref", 32'(req_ready), 0);
    end
    ref_ready = 1'b1;
    settle();
    chk("fr_rdy_hs", 32'(req_ready), 0);
    tick();
    chk("fr_ref41", 32'(ref_v), 0);
    chk("fr_pend41", 32'(ref_pending), 1);
    chk("fr_rdy41", 32'(req_ready), 32'h2);
    chk("fr_maxpend", 32'(max_pend), 2);
    ref_ready = 1'b0;
    req_v = '0;

    // refresh handshake coincides with timer expiry
    rst_on();
    rst_off();
    repeat (17) tick();
    chk("si_ref17", 32'(ref_v), 1);
    repeat (14) tick();
    chk("si_pend31", 32'(ref_pending), 1);
    ref_ready = 1'b1;
    tick();
    chk("si_pend32", 32'(ref_pending), 1);
    chk("si_ref32", 32'(ref_v), 0);
    tick();
    chk("si_ref33", 32'(ref_v), 1);
    tick();
    chk("si_pend34", 32'(ref_pending), 0);
    ref_ready = 1'b0;

    // reset in the middle of traffic
    rst_on();
    rst_off();
    req_v = 4'b1111;
    repeat (10) tick();
    chk("mr_pre_v", 32'(cmd_v), 1);
    rst_on();
    chk("mr_v", 32'(cmd_v), 0);
    chk("mr_id", 32'(cmd_id), 0);
    chk("mr_addr", 32'(cmd_addr), 0);
    chk("mr_ref", 32'(ref_v), 0);
    rst_off();
    settle();
    chk("mr_ptr", 32'(req_ready), 32'h1);
    tick();
    chk("mr_id1", 32'(cmd_id), 0);
    req_v = '0;
    repeat (14) tick();
    chk("mr_pend15", 32'(ref_pending), 0);
    tick();
    chk("mr_pend16", 32'(ref_pending), 1);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

  always @(negedge clk)
    if (reset_n && cmd_v && ref_v) begin
      n_chk++;
      n_err++;
      $display("FAIL excl: cmd_v %0d ref_v %0d both set", cmd_v, ref_v);
    end

endmodule

// File: doc/bsg_dmc_req_sched.md
# bsg_dmc_req_sched

Round-robin command scheduler that shares the single DRAM controller command port among `num_req_p` on-chip requesters and interleaves the periodic refresh commands the DRAM needs. It sits in `bsg_chip_guts` between the requester fabric and the DMC front end, in the core clock domain. It issues one registered command per handshake, with back-to-back issue, and supports bounded refresh postponement with forced refresh on overflow.

## Interface
- `num_req_p`, 4: number of requesters, at least 2.
- `addr_width_p`, 28: command address width.
- `refresh_interval_p`, 780: cycles between refresh credits, at least 2.
- `max_postpone_p`, 8: pending-refresh count that forces a refresh, at least 1.

- `clk_i` in 1: core clock; the only clock.
- `reset_n_i` in 1: reset; asynchronous, active-low.
- `req_v_i` in `num_req_p`: request valid, one bit per requester.
- `req_we_i` in `num_req_p`: 1 = write, 0 = read.
- `req_addr_i` in `num_req_p` x `addr_width_p`: request address.
- `req_ready_o` out `num_req_p`: one-hot or zero. A transfer happens when `req_v_i[i] & req_ready_o[i]`.
- `cmd_v_o` out 1: command valid (registered).
- `cmd_we_o` out 1: registered write flag.
- `cmd_addr_o` out `addr_width_p`: registered address.
- `cmd_id_o` out `$clog2(num_req_p)`: index of the granted requester.
- `cmd_ready_i` in 1: DMC accepts the command.
- `ref_v_o` out 1: refresh request (registered).
- `ref_ready_i` in 1: DMC accepts the refresh.
- `ref_pending_o` out `$clog2(max_postpone_p+1)`: count of owed refreshes.

## Operation
- FSM states:
  - IDLE: no output valid.
  - CMD: `cmd_v_o`=1 and the command registers are held.
  - REF: `ref_v_o`=1.
- A load slot exists when `state==IDLE`, or when `state==CMD & cmd_ready_i`. REF never loads; on `ref_ready_i` it returns to IDLE.
- In a load slot, priority is:
  1. forced refresh (`pending==max_postpone_p`): go to REF; all `req_ready_o`=0.
  2. any `req_v_i`: the round-robin winner `w` gets `req_ready_o[w]`=1; capture `we`, `addr` and `w`; go to CMD.
  3. `pending>0`: opportunistic refresh; go to REF.
  4. otherwise go to IDLE (from CMD, only if the handshake occurred).
- `req_ready_o` is combinational from `req_v_i`, the state, `cmd_ready_i` and `pending`. It is never asserted outside a load slot.
- Round-robin pointer `p`:
  - The search starts at `p`, wraps modulo `num_req_p`, and takes the first set `req_v_i`.
  - After a grant to `w`, `p` = (`w`+1) mod `num_req_p`.
  - `p` does not change on refresh or idle.
- Refresh timer:
  - Down-counter reloaded to `refresh_interval_p-1`.
  - When it reaches 0, it reloads and `pending` increments, saturating at `max_postpone_p`.
- `pending` decrements on the `ref_v_o & ref_ready_i` handshake. If the timer expires in the same cycle as the handshake, `pending` is unchanged.
- If saturation is reached while in CMD, the forced refresh takes the next load slot. Refresh is never inserted mid-handshake.
- Invariants:
  - `cmd_v_o & ref_v_o` is never 1.
  - Command registers do not change while `cmd_v_o & ~cmd_ready_i`.

## Timing
- Reset values:
  - state IDLE.
  - `cmd_v_o`=0, `ref_v_o`=0.
  - `cmd_we_o`=0, `cmd_addr_o`=0, `cmd_id_o`=0.
  - `p`=0, `pending`=0, timer=`refresh_interval_p-1`.
  - `ref_pending_o`=0.
- Latency: request accepted in cycle t → `cmd_v_o`=1 in t+1.
- Throughput: with `cmd_ready_i` held at 1, one command per cycle.
- Refresh: the first credit appears `refresh_interval_p` cycles after reset deassertion. `ref_v_o` rises one cycle after the deciding load slot.
- Reset asserted mid-operation: all state clears immediately (asynchronous). Any in-flight command or refresh is dropped; upstream must re-issue.
- `ref_pending_o` is the registered `pending` value.

## Structure
- `bsg_dmc_pkg` holds:
  - the shared `bsg_dmc_cmd_s` typedef (`we`, `addr`).
  - the FSM state enum.
  - the refresh defaults (interval 780 @ tREFI/period, postpone 8) used by `bsg_chip_guts`.
- One sub-module: `bsg_dmc_rr_pick`. It is a combinational rotate-priority-encoder taking `req_v_i` and `p`, and producing a one-hot grant and `w`.
- The pointer, timer, `pending` counter and FSM live in the top module.

## Test plan
Bench parameters: `num_req_p`=4, `refresh_interval_p`=16, `max_postpone_p`=2.

- **Round robin:** `req_v_i`=4'b1111 held, `cmd_ready_i`=1 → `cmd_id_o` sequence 0,1,2,3,0 on consecutive cycles starting cycle 1; `cmd_addr_o` matches the granted requester.
- **Backpressure:** `cmd_ready_i`=0 for 5 cycles with a command pending → `cmd_*` stable, `req_ready_o`=0; release → next grant the same cycle `cmd_ready_i`=1.
- **Opportunistic refresh:** no requests → `ref_v_o` asserts cycle 17 after reset deassertion; `ref_ready_i`=1 → `ref_pending_o` returns to 0.
- **Forced refresh:**
  - Setup: requester 1 continuously valid, `ref_ready_i`=0.
  - Required: `pending` reaches 2 at cycle 32 → next load slot enters REF, `req_ready_o`=0 until `ref_ready_i`.
  - Check: `pending` never exceeds 2.
- **Simultaneous event:** refresh handshake in the same cycle as timer expiry → `ref_pending_o` unchanged.
- **Reset mid-operation:** `reset_n_i` low while `cmd_v_o`=1 → outputs 0 immediately, pointer=0, timer reloaded.
